ntt_bf_scheduler: RTL and testbench
===================================

# ntt_bf_scheduler

Sequencing controller for the radix-2 butterfly datapath of the Dilithium NTT (q = 8380417, N = 256). It walks the 8-stage Cooley–Tukey loop nest (len, start, j) and issues one butterfly per cycle as a read-address pair plus twiddle index to the coefficient RAM and butterfly unit. It delays the same addresses by the butterfly pipeline latency to drive write-back, and drains the pipeline between stages so no stage reads stale data.

## Interface
- N, 256, polynomial length (power of 2)
- LOGN, 8, log2(N); number of stages
- BF_LAT, 4, butterfly pipeline latency in cycles (≥1), read issue → write-back
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request; sampled only in IDLE
- inv  in  1  0 = forward NTT, 1 = inverse (present only with NTT_INVERSE_EN)
- busy  out  1  high from cycle after accepted start through done cycle
- done  out  1  one-cycle pulse at completion
- rd_en  out  1  butterfly issue strobe
- rd_addr_a  out  LOGN  index j
- rd_addr_b  out  LOGN  index j+len
- zeta_idx  out  LOGN  twiddle ROM index k, valid with rd_en
- bf_gs  out  1  0 = CT butterfly, 1 = GS butterfly; valid with rd_en
- wr_en  out  1  write-back strobe (rd_en delayed BF_LAT)
- wr_addr_a  out  LOGN  rd_addr_a delayed BF_LAT
- wr_addr_b  out  LOGN  rd_addr_b delayed BF_LAT

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: start=1 → ISSUE; loads len=N/2, start_idx=0, j=0, k=1, stage=0.
- ISSUE: one butterfly per cycle, rd_en=1, rd_addr_a=j, rd_addr_b=j+len, zeta_idx=k. j increments; when j = start_idx+len−1, start_idx += 2·len, j = new start_idx, k += 1. After the stage's N/2-th issue → DRAIN, counter = BF_LAT.
- DRAIN: rd_en=0 for BF_LAT cycles. At exit: stage < LOGN−1 → len halves, start_idx=j=0, stage+1, → ISSUE. Otherwise → DONE.
- DONE: done=1, busy=1 for one cycle → IDLE.
- k is not reset between stages. Forward run sweeps k = 1..255 exactly once.
- Width rules: all indices are LOGN bits. start_idx+2·len is computed in LOGN+1 bits; a value of N marks end of stage. k never exceeds N−1.
- start while not IDLE: ignored, no queuing.
- rst_n low at any time, including mid-stage: state → IDLE, all counters cleared, delay line flushed (wr_en=0 next edge after release). Partial RAM contents are undefined.

## Timing
- Reset values: busy=0, done=0, rd_en=0, wr_en=0, bf_gs=0, all address/index outputs 0.
- All outputs registered. start sampled at edge T (IDLE) gives first rd_en at T+1.
- Each stage is N/2 issue cycles + BF_LAT drain cycles. The last write of a stage coincides with the last DRAIN cycle, and the next stage's first read is the following cycle (RAM is read-after-write safe across cycles).
- done at T+1+LOGN·(N/2+BF_LAT). With defaults, first rd_en at cycle 1 and done at cycle 1057.
- wr_* equals rd_* exactly BF_LAT cycles earlier, cycle for cycle.

## Configuration
- NTT_INVERSE_EN defined: inv port exists and is latched at accepted start. For inv=1, stages run len = 1,2,…,N/2 (len doubles at DRAIN exit). k starts at N−1 and decrements per block (255..1). bf_gs=1 on every issue. Scaling by N⁻¹ is not done here; the downstream block performs it.
- Undefined: no inv port, forward schedule only, bf_gs tied 0.

## Structure
- Shared package ntt_pkg: N, LOGN, Q = 23'd8380417, state enum (IDLE/ISSUE/DRAIN/DONE), BF_LAT default.
- One sub-module, ntt_addr_delay: BF_LAT-deep shift register carrying {en, addr_a, addr_b} with async clear, instantiated once for the write-back path.

## Test plan
- Reset mid-run: deassert rst_n during stage 3 issue → all outputs 0 immediately; restart gives full, correct 1057-cycle run.
- Forward sequence: start at cycle 0 → rd_en cycles 1..128 with (a,b,k) = (0,128,1)…(127,255,1). Cycle 133 issues (0,64,2), cycle 197 issues (128,192,3). done at cycle 1057 only.
- Twiddle coverage: log zeta_idx over a full forward run → each of 1..255 appears in exactly 2^(7−s) consecutive issues of stage s, last stage (0,1,128)…(254,255,255).
- Write-back alignment with BF_LAT=4 and BF_LAT=1 → wr_* matches rd_* shifted by BF_LAT. No rd_en overlaps an outstanding write of the previous stage; totals are 1024 rd_en and 1024 wr_en.
- start held high through the run and re-pulsed while busy → exactly one run. A start pulse in the cycle after done → second run begins.
- NTT_INVERSE_EN, inv=1 → first issues (0,1,255),(2,3,254), bf_gs=1. Final stage (0,128,1)…(127,255,1), done at cycle 1057.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants and FSM state type for the Dilithium NTT butterfly scheduler.
// Holds the default polynomial size, stage count, modulus and butterfly latency.
package ntt_pkg;

    localparam int          N      = 256;
    localparam int          LOGN   = 8;
    localparam int          BF_LAT = 4;
    localparam logic [22:0] Q      = 23'd8380417;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ntt_addr_delay.sv
// Fixed-depth shift register that carries the butterfly read strobe and address pair
// forward to the write-back port; async clear so no stale write survives a reset.
module ntt_addr_delay #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic [W-1:0] i_addrA,
    input  logic [W-1:0] i_addrB,
    output logic         o_en,
    output logic [W-1:0] o_addrA,
    output logic [W-1:0] o_addrB
);

    logic [2*W:0] r_pipe [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= {i_en, i_addrA, i_addrB};
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_en    = r_pipe[DEPTH-1][2*W];
    assign o_addrA = r_pipe[DEPTH-1][2*W-1:W];
    assign o_addrB = r_pipe[DEPTH-1][W-1:0];

endmodule

// File: rtl/ntt_bf_scheduler.sv
// Radix-2 NTT butterfly sequencer: walks the (len, start, j) loop nest, one issue per cycle,
// with a drain gap between stages. Define NTT_INVERSE_EN for the inv port and GS/inverse schedule.
module ntt_bf_scheduler #(
    parameter int N      = ntt_pkg::N,
    parameter int LOGN   = ntt_pkg::LOGN,
    parameter int BF_LAT = ntt_pkg::BF_LAT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
`ifdef NTT_INVERSE_EN
    input  logic            inv,
`endif
    output logic            busy,
    output logic            done,
    output logic            rd_en,
    output logic [LOGN-1:0] rd_addr_a,
    output logic [LOGN-1:0] rd_addr_b,
    output logic [LOGN-1:0] zeta_idx,
    output logic            bf_gs,
    output logic            wr_en,
    output logic [LOGN-1:0] wr_addr_a,
    output logic [LOGN-1:0] wr_addr_b
);

    import ntt_pkg::*;

    localparam int STW = (LOGN > 1) ? $clog2(LOGN) : 1;
    localparam int DW  = $clog2(BF_LAT + 1);

    state_t          r_state, w_stateNext;
    logic [LOGN-1:0] r_len, w_lenNext;
    logic [LOGN-1:0] r_startIdx, w_startNext;
    logic [LOGN-1:0] r_j, w_jNext;
    logic [LOGN-1:0] r_k, w_kNext;
    logic [STW-1:0]  r_stage, w_stageNext;
    logic [DW-1:0]   r_drainCnt, w_drainNext;
    logic            r_inv, w_invNext;
    logic            w_invReq;

    logic [LOGN:0]   w_blockLast;
    logic [LOGN:0]   w_nextStart;
    logic            w_blockEnd;
    logic            w_stageEnd;
    logic            w_lastStage;
    logic [LOGN-1:0] w_kStep;

    logic            r_busy, r_done, r_rdEn, r_bfGs;
    logic [LOGN-1:0] r_rdAddrA, r_rdAddrB, r_zetaIdx;

`ifdef NTT_INVERSE_EN
    assign w_invReq = inv;
`else
    assign w_invReq = 1'b0;
`endif

    // Block/stage boundaries are evaluated one bit wider so start_idx + 2*len == N is representable.
    assign w_blockLast = {1'b0, r_startIdx} + {1'b0, r_len} - (LOGN+1)'(1);
    assign w_blockEnd  = ({1'b0, r_j} == w_blockLast);
    assign w_nextStart = {1'b0, r_startIdx} + {r_len, 1'b0};
    assign w_stageEnd  = (w_nextStart == (LOGN+1)'(N));
    assign w_lastStage = (r_stage == STW'(LOGN - 1));
    assign w_kStep     = r_inv ? (r_k - LOGN'(1)) : (r_k + LOGN'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_startIdx <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_stage    <= '0;
            r_drainCnt <= '0;
            r_inv      <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_len      <= w_lenNext;
            r_startIdx <= w_startNext;
            r_j        <= w_jNext;
            r_k        <= w_kNext;
            r_stage    <= w_stageNext;
            r_drainCnt <= w_drainNext;
            r_inv      <= w_invNext;
        end
    end

    // k carries across stage boundaries; it only stops stepping after the final block of the run.
    always_comb begin
        w_stateNext = r_state;
        w_lenNext   = r_len;
        w_startNext = r_startIdx;
        w_jNext     = r_j;
        w_kNext     = r_k;
        w_stageNext = r_stage;
        w_drainNext = r_drainCnt;
        w_invNext   = r_inv;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_stateNext = ISSUE;
                    w_invNext   = w_invReq;
                    w_lenNext   = w_invReq ? LOGN'(1) : LOGN'(N / 2);
                    w_kNext     = w_invReq ? LOGN'(N - 1) : LOGN'(1);
                    w_startNext = '0;
                    w_jNext     = '0;
                    w_stageNext = '0;
                    w_drainNext = '0;
                end
            end
            ISSUE: begin
                if (w_blockEnd) begin
                    if (w_stageEnd) begin
                        w_stateNext = DRAIN;
                        w_drainNext = DW'(BF_LAT);
                        if (!w_lastStage) begin
                            w_kNext = w_kStep;
                        end
                    end else begin
                        w_startNext = w_nextStart[LOGN-1:0];
                        w_jNext     = w_nextStart[LOGN-1:0];
                        w_kNext     = w_kStep;
                    end
                end else begin
                    w_jNext = r_j + LOGN'(1);
                end
            end
            DRAIN: begin
                if (r_drainCnt == DW'(1)) begin
                    if (w_lastStage) begin
                        w_stateNext = DONE;
                    end else begin
                        w_stateNext = ISSUE;
                        w_lenNext   = r_inv ? (r_len << 1) : (r_len >> 1);
                        w_startNext = '0;
                        w_jNext     = '0;
                        w_stageNext = r_stage + STW'(1);
                    end
                end else begin
                    w_drainNext = r_drainCnt - DW'(1);
                end
            end
            DONE: begin
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Outputs are registered one cycle behind the loop counters; idle address fields read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rdEn    <= 1'b0;
            r_bfGs    <= 1'b0;
            r_rdAddrA <= '0;
            r_rdAddrB <= '0;
            r_zetaIdx <= '0;
        end else begin
            r_busy <= (r_state != IDLE);
            r_done <= (r_state == DONE);
            r_rdEn <= (r_state == ISSUE);
            if (r_state == ISSUE) begin
                r_rdAddrA <= r_j;
                r_rdAddrB <= r_j + r_len;
                r_zetaIdx <= r_k;
                r_bfGs    <= r_inv;
            end else begin
                r_rdAddrA <= '0;
                r_rdAddrB <= '0;
                r_zetaIdx <= '0;
                r_bfGs    <= 1'b0;
            end
        end
    end

    ntt_addr_delay #(
        .DEPTH (BF_LAT),
        .W     (LOGN)
    ) u_wrDelay (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (r_rdEn),
        .i_addrA (r_rdAddrA),
        .i_addrB (r_rdAddrB),
        .o_en    (wr_en),
        .o_addrA (wr_addr_a),
        .o_addrB (wr_addr_b)
    );

    assign busy      = r_busy;
    assign done      = r_done;
    assign rd_en     = r_rdEn;
    assign rd_addr_a = r_rdAddrA;
    assign rd_addr_b = r_rdAddrB;
    assign zeta_idx  = r_zetaIdx;
    assign bf_gs     = r_bfGs;

endmodule

// File: tb/tb_ntt_bf_scheduler.sv
// Self-checking bench for ntt_bf_scheduler: two instances (BF_LAT=4 and BF_LAT=1) compared each
// cycle against a loop-nest schedule model; inverse runs only when NTT_INVERSE_EN is defined.
module tb_ntt_bf_scheduler;

    localparam int N     = 256;
    localparam int LOGN  = 8;
    localparam int MAXRC = 1100;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic inv;

    logic       busyS [2];
    logic       doneS [2];
    logic       rdEnS [2];
    logic       gsS   [2];
    logic       wrEnS [2];
    logic [7:0] aS    [2];
    logic [7:0] bS    [2];
    logic [7:0] kS    [2];
    logic [7:0] waS   [2];
    logic [7:0] wbS   [2];

    logic       mEn  [2][MAXRC];
    logic       mGs  [2][MAXRC];
    logic [7:0] mA   [2][MAXRC];
    logic [7:0] mB   [2][MAXRC];
    logic [7:0] mK   [2][MAXRC];
    int         mDone[2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ntt_bf_scheduler #(.N(N), .LOGN(LOGN), .BF_LAT(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
`ifdef NTT_INVERSE_EN
        .inv       (inv),
`endif
        .busy      (busyS[0]),
        .done      (doneS[0]),
        .rd_en     (rdEnS[0]),
        .rd_addr_a (aS[0]),
        .rd_addr_b (bS[0]),
        .zeta_idx  (kS[0]),
        .bf_gs     (gsS[0]),
        .wr_en     (wrEnS[0]),
        .wr_addr_a (waS[0]),
        .wr_addr_b (wbS[0])
    );

    ntt_bf_scheduler #(.N(N), .LOGN(LOGN), .BF_LAT(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
`ifdef NTT_INVERSE_EN
        .inv       (inv),
`endif
        .busy      (busyS[1]),
        .done      (doneS[1]),
        .rd_en     (rdEnS[1]),
        .rd_addr_a (aS[1]),
        .rd_addr_b (bS[1]),
        .zeta_idx  (kS[1]),
        .bf_gs     (gsS[1]),
        .wr_en     (wrEnS[1]),
        .wr_addr_a (waS[1]),
        .wr_addr_b (wbS[1])
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [44:0] actBus(input int inst);
        return {busyS[inst], doneS[inst], rdEnS[inst], aS[inst], bS[inst], kS[inst], gsS[inst],
                wrEnS[inst], waS[inst], wbS[inst]};
    endfunction

    function automatic int latOf(input int inst);
        return (inst == 0) ? 4 : 1;
    endfunction

    // Expected issue schedule straight from the loop nest; rc counts cycles after the accepting edge.
    task automatic buildModel(input bit invRun);
        for (int inst = 0; inst < 2; inst++) begin
            int lat;
            int k;
            int len;
            lat = latOf(inst);
            for (int rc = 0; rc < MAXRC; rc++) begin
                mEn[inst][rc] = 1'b0;
                mGs[inst][rc] = 1'b0;
                mA[inst][rc]  = 8'd0;
                mB[inst][rc]  = 8'd0;
                mK[inst][rc]  = 8'd0;
            end
            mDone[inst] = 1 + LOGN * (N / 2 + lat);
            k   = invRun ? N - 1 : 1;
            len = invRun ? 1 : N / 2;
            for (int s = 0; s < LOGN; s++) begin
                int i;
                i = 0;
                for (int st = 0; st < N; st += 2 * len) begin
                    for (int j = st; j < st + len; j++) begin
                        int rc;
                        rc = 1 + s * (N / 2 + lat) + i;
                        mEn[inst][rc] = 1'b1;
                        mGs[inst][rc] = invRun;
                        mA[inst][rc]  = 8'(j);
                        mB[inst][rc]  = 8'(j + len);
                        mK[inst][rc]  = 8'(k);
                        i++;
                    end
                    k = invRun ? k - 1 : k + 1;
                end
                len = invRun ? len * 2 : len / 2;
            end
        end
    endtask

    function automatic logic [44:0] expBus(input int inst, input int rc);
        int   lat;
        logic wE;
        logic [7:0] wA, wB;
        lat = latOf(inst);
        wE = 1'b0;
        wA = 8'd0;
        wB = 8'd0;
        if (rc >= lat) begin
            wE = mEn[inst][rc-lat];
            wA = mA[inst][rc-lat];
            wB = mB[inst][rc-lat];
        end
        return {(rc >= 1 && rc <= mDone[inst]), (rc == mDone[inst]), mEn[inst][rc], mA[inst][rc],
                mB[inst][rc], mK[inst][rc], mGs[inst][rc], wE, wA, wB};
    endfunction

    // One full run: start asserted for the accepting edge, optionally held or re-pulsed, every cycle compared.
    task automatic applyStimulus(input bit invRun, input int holdUntil, input int pulseRc,
                                 input int endRc, input bit checkCov, input string tag);
        int rdCnt [2];
        int wrCnt [2];
        int kCount [256];
        rdCnt = '{0, 0};
        wrCnt = '{0, 0};
        for (int i = 0; i < 256; i++) kCount[i] = 0;
        buildModel(invRun);
        inv   = invRun;
        start = 1'b1;
        for (int rc = 0; rc <= endRc; rc++) begin
            @(posedge clk);
            #1;
            for (int inst = 0; inst < 2; inst++) begin
                checkOutput($sformatf("%s dut%0d rc%0d", tag, inst, rc), 64'(actBus(inst)),
                            64'(expBus(inst, rc)));
                if (rdEnS[inst] === 1'b1) rdCnt[inst]++;
                if (wrEnS[inst] === 1'b1) wrCnt[inst]++;
            end
            if (rdEnS[0] === 1'b1) kCount[kS[0]]++;
            start = ((rc + 1) < holdUntil) || ((rc + 1) == pulseRc);
        end
        start = 1'b0;
        for (int inst = 0; inst < 2; inst++) begin
            checkOutput($sformatf("%s dut%0d rd_en total", tag, inst), 64'(rdCnt[inst]), 64'd1024);
            checkOutput($sformatf("%s dut%0d wr_en total", tag, inst), 64'(wrCnt[inst]), 64'd1024);
        end
        if (checkCov) begin
            for (int k = 1; k < 256; k++) begin
                int s;
                s = 0;
                while ((1 << (s + 1)) <= k) s++;
                checkOutput($sformatf("%s zeta %0d count", tag, k), 64'(kCount[k]), 64'(1 << (7 - s)));
            end
        end
    endtask

    task automatic checkAllZero(input string tag);
        for (int inst = 0; inst < 2; inst++) begin
            checkOutput($sformatf("%s dut%0d outputs", tag, inst), 64'(actBus(inst)), 64'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        inv   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        buildModel(1'b0);
        checkOutput("pin fwd rc1",    {mA[0][1],    mB[0][1],    mK[0][1]},    {8'd0,   8'd128, 8'd1});
        checkOutput("pin fwd rc128",  {mA[0][128],  mB[0][128],  mK[0][128]},  {8'd127, 8'd255, 8'd1});
        checkOutput("pin fwd rc133",  {mA[0][133],  mB[0][133],  mK[0][133]},  {8'd0,   8'd64,  8'd2});
        checkOutput("pin fwd rc197",  {mA[0][197],  mB[0][197],  mK[0][197]},  {8'd128, 8'd192, 8'd3});
        checkOutput("pin fwd rc925",  {mA[0][925],  mB[0][925],  mK[0][925]},  {8'd0,   8'd1,   8'd128});
        checkOutput("pin fwd rc1052", {mA[0][1052], mB[0][1052], mK[0][1052]}, {8'd254, 8'd255, 8'd255});
        checkOutput("pin gap rc129",  64'(mEn[0][129]), 64'd0);
        checkOutput("pin done lat4",  64'(mDone[0]), 64'd1057);
        checkOutput("pin done lat1",  64'(mDone[1]), 64'd1033);

        applyStimulus(1'b0, 1, -1, 1057, 1'b1, "fwd");
        applyStimulus(1'b0, 1, -1, 1057, 1'b0, "fwd back-to-back");
        applyStimulus(1'b0, 1000, 1020, 1070, 1'b0, "start held");

        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (409) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkAllZero("async reset mid stage3");
        @(posedge clk);
        #1;
        checkAllZero("held reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkAllZero("after reset release");
        applyStimulus(1'b0, 1, -1, 1057, 1'b1, "fwd after reset");

`ifdef NTT_INVERSE_EN
        buildModel(1'b1);
        checkOutput("pin inv rc1",    {mA[0][1],    mB[0][1],    mK[0][1]},    {8'd0,   8'd1,   8'd255});
        checkOutput("pin inv rc2",    {mA[0][2],    mB[0][2],    mK[0][2]},    {8'd2,   8'd3,   8'd254});
        checkOutput("pin inv rc925",  {mA[0][925],  mB[0][925],  mK[0][925]},  {8'd0,   8'd128, 8'd1});
        checkOutput("pin inv rc1052", {mA[0][1052], mB[0][1052], mK[0][1052]}, {8'd127, 8'd255, 8'd1});
        applyStimulus(1'b1, 1, -1, 1057, 1'b0, "inv");
        inv = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
